wram_port: RTL and testbench

WRAM_PORT -- requirements
Module: wram_port

---
 rtl/wram_port.sv | 124 ++++++++++++
 tb/tb_wram_port.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wram_port.sv
`default_nettype none
// ============================================================================
//  Module   : wram_port (with bus_pkg)
//  Purpose  : B-bus WMADD/WMDATA port into work RAM. Holds the auto-
//             incrementing WRAM address and runs one request/ack handshake
//             per WMDATA read or write strobe.
//  Revision : 1.0 - initial release
// ============================================================================

package bus_pkg;
  // Decoded B-bus operations delivered by the bus-B address decoder.
  typedef enum logic [3:0] {
    B_NOP      = 4'd0,
    B_INDISP   = 4'd1,
    B_WMDATA_R = 4'd2,
    B_WMDATA_W = 4'd3,
    B_WMADDL   = 4'd4,
    B_WMADDM   = 4'd5,
    B_WMADDH   = 4'd6
  } b_op_type;
endpackage

module wram_port #(
  parameter int ADDR_W = 17   // supported range 17..24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  bus_pkg::b_op_type    b_op,
  input  logic                 b_strobe,
  input  logic [7:0]           b_wdata,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 wram_req,
  output logic                 wram_we,
  output logic [ADDR_W-1:0]    wram_addr,
  output logic [7:0]           wram_wdata,
  input  logic                 wram_ack,
  input  logic [7:0]           wram_rdata
);

  // Width of the WMADDH field: only the low bits of the written byte land.
  localparam int H_W = ADDR_W - 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wmadd_q, wmadd_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                we_q,    we_d;
  logic [7:0]          wdata_q, wdata_d;

  // State and datapath registers; reset clears everything, dropping any request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      wmadd_q <= '0;
      rdata_q <= 8'h00;
      we_q    <= 1'b0;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      wmadd_q <= wmadd_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state: B-bus ops are only honoured in IDLE, acks only in REQ.
  // Address loads and the post-ack increment live in disjoint states, so
  // they can never collide.
  always_comb begin
    state_d = state_q;
    wmadd_d = wmadd_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (b_strobe) begin
          case (b_op)
            bus_pkg::B_WMADDL: wmadd_d[7:0]        = b_wdata;
            bus_pkg::B_WMADDM: wmadd_d[15:8]       = b_wdata;
            bus_pkg::B_WMADDH: wmadd_d[ADDR_W-1:16] = b_wdata[H_W-1:0];
            bus_pkg::B_WMDATA_W: begin
              we_d    = 1'b1;
              wdata_d = b_wdata;
              state_d = S_REQ;
            end
            bus_pkg::B_WMDATA_R: begin
              we_d    = 1'b0;
              state_d = S_REQ;
            end
            default: ;
          endcase
        end
      end
      S_REQ: begin
        if (wram_ack) begin
          state_d = S_DONE;
          wmadd_d = wmadd_q + ADDR_W'(1);
          if (!we_q) begin
            rdata_d = wram_rdata;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign wram_req   = (state_q == S_REQ);
  assign wram_we    = we_q;
  assign wram_addr  = wmadd_q;
  assign wram_wdata = wdata_q;
  assign rdata      = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wram_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wram_port
//  Purpose  : Self-checking bench for wram_port: directed B-bus sequences,
//             a memory responder, and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wram_port;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  b_op_type    b_op = B_NOP;
  logic        b_strobe = 1'b0;
  logic [7:0]  b_wdata = 8'h00;
  logic [7:0]  rdata;
  logic        busy;
  logic        wram_req;
  logic        wram_we;
  logic [16:0] wram_addr;
  logic [7:0]  wram_wdata;
  logic        wram_ack;
  logic [7:0]  wram_rdata = 8'h00;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wram_port #(.ADDR_W(17)) dut (
    .clk(clk), .reset(reset), .b_op(b_op), .b_strobe(b_strobe),
    .b_wdata(b_wdata), .rdata(rdata), .busy(busy), .wram_req(wram_req),
    .wram_we(wram_we), .wram_addr(wram_addr), .wram_wdata(wram_wdata),
    .wram_ack(wram_ack), .wram_rdata(wram_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // Read contents: fixed pattern with two pinned locations.
  function automatic logic [7:0] rom(input logic [16:0] a);
    if (a == 17'h1FFFF) return 8'h11;
    if (a == 17'h00000) return 8'h22;
    return a[7:0] ^ 8'h5A;
  endfunction

  logic        resp_ack = 1'b0;
  logic        stim_ack = 1'b0;
  logic        resp_en  = 1'b1;
  int          ack_delay = 1;
  int          cnt = 0;
  int          wr_count = 0;
  logic [16:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0;

  assign wram_ack = resp_ack | stim_ack;

  // Acks the ack_delay-th cycle that sees a request.
  always @(negedge clk) begin
    resp_ack <= 1'b0;
    if (reset || !resp_en || !wram_req || resp_ack) begin
      cnt <= 0;
    end else if (cnt + 1 == ack_delay) begin
      cnt        <= 0;
      resp_ack   <= 1'b1;
      wram_rdata <= rom(wram_addr);
      if (wram_we) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= wram_addr;
        last_wr_data <= wram_wdata;
      end
    end else begin
      cnt <= cnt + 1;
    end
  end

  // ---------------- reference model ----------------
  // Access-level view: an accepted WMDATA op opens an access that stays
  // pending until acknowledged; the port stays busy one more cycle after.
  logic [16:0] m_wmadd = '0;
  logic [7:0]  m_rdata = '0;
  logic        m_we    = 1'b0;
  logic [7:0]  m_wdata = '0;
  logic        m_pend  = 1'b0;
  int          m_tail  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_wmadd <= '0; m_rdata <= '0; m_we <= 1'b0; m_wdata <= '0;
      m_pend  <= 1'b0; m_tail <= 0;
    end else begin
      if (m_tail > 0) m_tail <= m_tail - 1;
      if (m_pend) begin
        if (wram_ack) begin
          m_pend  <= 1'b0;
          m_tail  <= 1;
          m_wmadd <= 17'((32'(m_wmadd) + 1) % 131072);
          if (!m_we) m_rdata <= wram_rdata;
        end
      end else if (m_tail == 0 && b_strobe) begin
        case (b_op)
          B_WMADDL:   m_wmadd <= {m_wmadd[16:8], b_wdata};
          B_WMADDM:   m_wmadd <= {m_wmadd[16], b_wdata, m_wmadd[7:0]};
          B_WMADDH:   m_wmadd <= {b_wdata[0], m_wmadd[15:0]};
          B_WMDATA_W: begin m_we <= 1'b1; m_wdata <= b_wdata; m_pend <= 1'b1; end
          B_WMDATA_R: begin m_we <= 1'b0; m_pend <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      chk("busy", 32'(busy), 32'(m_pend || m_tail != 0));
      chk("wram_req", 32'(wram_req), 32'(m_pend));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (m_pend) begin
        chk("wram_addr", 32'(wram_addr), 32'(m_wmadd));
        chk("wram_we", 32'(wram_we), 32'(m_we));
        if (m_we) chk("wram_wdata", 32'(wram_wdata), 32'(m_wdata));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic strobe(input b_op_type op, input logic [7:0] d);
    @(negedge clk);
    b_op = op; b_strobe = 1'b1; b_wdata = d;
    @(negedge clk);
    b_op = B_NOP; b_strobe = 1'b0; b_wdata = 8'h00;
  endtask

  task automatic set_addr(input logic [7:0] h, input logic [7:0] m, input logic [7:0] l);
    strobe(B_WMADDL, l);
    strobe(B_WMADDM, m);
    strobe(B_WMADDH, h);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Read access; checks the address presented in the first request cycle.
  task automatic read_at(input string name, input logic [16:0] exp_addr);
    strobe(B_WMDATA_R, 8'h00);
    chk({name, "_req"}, 32'(wram_req), 32'd1);
    chk({name, "_addr"}, 32'(wram_addr), 32'(exp_addr));
    wait_idle(20);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req", 32'(wram_req), 32'd0);
    chk("rst_we", 32'(wram_we), 32'd0);
    chk("rst_wdata", 32'(wram_wdata), 32'h00);
    reset = 1'b0;
    @(negedge clk);

    // Address load with unused WMADDH bits set.
    ack_delay = 1;
    set_addr(8'hFF, 8'h12, 8'h34);
    read_at("load", 17'h11234);
    chk("load_rdata", 32'(rdata), 32'h6E);

    // Single write, ack on the third request cycle.
    set_addr(8'h00, 8'h00, 8'h10);
    ack_delay = 3;
    strobe(B_WMDATA_W, 8'hA5);
    chk("wr_req", 32'(wram_req), 32'd1);
    chk("wr_we", 32'(wram_we), 32'd1);
    chk("wr_addr", 32'(wram_addr), 32'h00010);
    chk("wr_wdata", 32'(wram_wdata), 32'hA5);
    n = 0;
    while (!resp_ack && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk("wr_ack_seen", 32'(resp_ack), 32'd1);
    @(negedge clk);
    chk("wr_busy_ack+1", 32'(busy), 32'd1);
    @(negedge clk);
    chk("wr_busy_ack+2", 32'(busy), 32'd0);
    chk("wr_count", 32'(wr_count), 32'd1);
    chk("wr_mem_addr", 32'(last_wr_addr), 32'h00010);
    chk("wr_mem_data", 32'(last_wr_data), 32'hA5);
    ack_delay = 1;
    read_at("wr_inc", 17'h00011);

    // Burst read across the address wrap.
    set_addr(8'h01, 8'hFF, 8'hFF);
    read_at("burst0", 17'h1FFFF);
    chk("burst0_rdata", 32'(rdata), 32'h11);
    read_at("burst1", 17'h00000);
    chk("burst1_rdata", 32'(rdata), 32'h22);
    read_at("burst_after", 17'h00001);

    // Ops strobed while busy are dropped.
    ack_delay = 6;
    strobe(B_WMDATA_W, 8'h5A);
    strobe(B_WMADDL, 8'h77);
    strobe(B_WMDATA_W, 8'h99);
    wait_idle(20);
    chk("busy_wr_count", 32'(wr_count), 32'd2);
    chk("busy_wr_data", 32'(last_wr_data), 32'h5A);
    chk("busy_wr_addr", 32'(last_wr_addr), 32'h00002);
    ack_delay = 1;
    read_at("busy_addr", 17'h00003);

    // Reset in the middle of a request.
    resp_en = 1'b0;
    strobe(B_WMDATA_W, 8'hC3);
    chk("mid_req", 32'(wram_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req", 32'(wram_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_rdata", 32'(rdata), 32'h00);
    chk("mid_rst_we", 32'(wram_we), 32'd0);
    chk("mid_rst_wdata", 32'(wram_wdata), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    stim_ack = 1'b1;
    @(negedge clk);
    stim_ack = 1'b0;
    @(negedge clk);
    chk("stray_busy", 32'(busy), 32'd0);
    chk("stray_wr_count", 32'(wr_count), 32'd2);
    read_at("stray_addr", 17'h00000);
    chk("stray_rdata", 32'(rdata), 32'h22);

    // Spurious ack in IDLE and an unrelated B-bus op.
    @(negedge clk);
    stim_ack = 1'b1;
    @(negedge clk);
    stim_ack = 1'b0;
    strobe(B_INDISP, 8'h55);
    @(negedge clk);
    chk("spur_busy", 32'(busy), 32'd0);
    chk("spur_rdata", 32'(rdata), 32'h22);
    read_at("spur_addr", 17'h00001);
    chk("spur_rdata2", 32'(rdata), 32'h5B);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Absolute time guard.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
